// File: rtl/usb_bulk_out_fifo.sv
// Bulk OUT endpoint receive FIFO: captures packets from the USB core, commits or rolls back
// each one, and streams committed bytes out. Optional macro USB_OUT_FIFO_STALL_EN adds a halt input.
module usb_bulk_out_fifo #(
  parameter int ENDPOINT   = 1,
  parameter int DEPTH_LOG2 = 7,
  parameter int MAX_PACKET = 64
) (
  input  logic                  clk_48,
  input  logic                  rst_n,
  input  logic                  usb_rst,
  input  logic [3:0]            endpoint,
  input  logic                  transaction_active,
  input  logic                  direction_in,
  input  logic                  setup,
  input  logic [7:0]            data_out,
  input  logic                  data_strobe,
  input  logic                  success,
  input  logic                  clear_toggle,
`ifdef USB_OUT_FIFO_STALL_EN
  input  logic                  halt,
`endif
  output logic [1:0]            handshake,
  output logic                  data_toggle,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [7:0]            pkt_count
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int CW = $clog2(MAX_PACKET + 1);
  localparam logic [CW-1:0] MAXP     = CW'(MAX_PACKET);
  localparam logic [PW:0]   MAXP_W   = (PW+1)'(MAX_PACKET);
  localparam logic [PW:0]   DEPTH    = (PW+1)'(2**DEPTH_LOG2);
  localparam logic [3:0]    EP       = 4'(ENDPOINT);
  localparam logic [1:0]    HS_ACK   = 2'b00;
  localparam logic [1:0]    HS_NAK   = 2'b10;
`ifdef USB_OUT_FIFO_STALL_EN
  localparam logic [1:0]    HS_STALL = 2'b11;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP, S_END} state_t;

  state_t          state;
  logic [7:0]      mem [2**DEPTH_LOG2];
  logic [PW-1:0]   wr_ptr, rd_ptr, shadow_ptr;
  logic [CW-1:0]   byte_cnt;
  logic            ovf, sel_q, strobe_q, ta_q;
  logic            sel, sel_rise, strobe_rise, ta_fall, do_reset, wr_en, room, pop;
  logic [PW:0]     free;
`ifdef USB_OUT_FIFO_STALL_EN
  logic            halt_q;
`endif

  assign sel         = transaction_active && (endpoint == EP) && !direction_in && !setup;
  assign sel_rise    = sel && !sel_q;
  assign strobe_rise = data_strobe && !strobe_q;
  assign ta_fall     = ta_q && !transaction_active;
  assign do_reset    = !rst_n || usb_rst;

  // Only committed bytes count toward level; shadow bytes stay invisible to the reader.
  assign level    = wr_ptr - rd_ptr;
  assign free     = DEPTH - {1'b0, level};
  assign room     = free >= MAXP_W;
  assign rd_valid = level != '0;
  assign rd_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign pop      = rd_valid && rd_ready;
  assign wr_en    = !do_reset && state == S_RECV && strobe_rise && byte_cnt < MAXP;

  always_ff @(posedge clk_48) begin
    if (wr_en) mem[shadow_ptr[DEPTH_LOG2-1:0]] <= data_out;
  end

  always_ff @(posedge clk_48) begin
    if (do_reset) begin
      state       <= S_IDLE;
      handshake   <= HS_NAK;
      data_toggle <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      shadow_ptr  <= '0;
      byte_cnt    <= '0;
      ovf         <= 1'b0;
      pkt_count   <= '0;
      sel_q       <= 1'b0;
      strobe_q    <= 1'b0;
      ta_q        <= 1'b0;
`ifdef USB_OUT_FIFO_STALL_EN
      halt_q      <= 1'b0;
`endif
    end else begin
      sel_q    <= sel;
      strobe_q <= data_strobe;
      ta_q     <= transaction_active;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case (state)
        S_IDLE: begin
          handshake <= HS_NAK;
          if (sel_rise) begin
`ifdef USB_OUT_FIFO_STALL_EN
            if (halt) begin
              handshake <= HS_STALL;
              state     <= S_DROP;
            end else
`endif
            if (room) begin
              shadow_ptr <= wr_ptr;
              byte_cnt   <= '0;
              ovf        <= 1'b0;
              handshake  <= HS_ACK;
              state      <= S_RECV;
            end else begin
              handshake <= HS_NAK;
              state     <= S_DROP;
            end
          end
        end
        S_RECV: begin
          if (strobe_rise) begin
            if (byte_cnt < MAXP) begin
              shadow_ptr <= shadow_ptr + 1'b1;
              byte_cnt   <= byte_cnt + 1'b1;
            end else begin
              ovf <= 1'b1;
            end
          end
          if (ta_fall) state <= S_END;
        end
        S_DROP: begin
          if (ta_fall) begin
            state     <= S_IDLE;
            handshake <= HS_NAK;
          end
        end
        S_END: begin
`ifdef USB_OUT_FIFO_STALL_EN
          if (success && !ovf && !halt) begin
`else
          if (success && !ovf) begin
`endif
            wr_ptr      <= shadow_ptr;
            data_toggle <= ~data_toggle;
            pkt_count   <= pkt_count + 8'd1;
          end
          state     <= S_IDLE;
          handshake <= HS_NAK;
        end
        default: state <= S_IDLE;
      endcase
      // Clear overrides any flip scheduled by the END state above.
      if (clear_toggle) data_toggle <= 1'b0;
`ifdef USB_OUT_FIFO_STALL_EN
      halt_q <= halt;
      if (halt_q && !halt) data_toggle <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_usb_bulk_out_fifo.sv
// Directed bench for usb_bulk_out_fifo; a scoreboard queue holds committed bytes and a
// negedge monitor checks every accepted read against it.
module tb_usb_bulk_out_fifo;

  logic       clk_48 = 1'b0;
  logic       rst_n, usb_rst, transaction_active, direction_in, setup;
  logic [3:0] endpoint;
  logic [7:0] data_out;
  logic       data_strobe, success, clear_toggle, rd_ready;
  logic [1:0] handshake;
  logic       data_toggle, rd_valid;
  logic [7:0] rd_data, pkt_count;
  logic [7:0] level;
`ifdef USB_OUT_FIFO_STALL_EN
  logic       halt = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  usb_bulk_out_fifo #(.ENDPOINT(1), .DEPTH_LOG2(7), .MAX_PACKET(64)) dut (
    .clk_48(clk_48), .rst_n(rst_n), .usb_rst(usb_rst), .endpoint(endpoint),
    .transaction_active(transaction_active), .direction_in(direction_in), .setup(setup),
    .data_out(data_out), .data_strobe(data_strobe), .success(success),
    .clear_toggle(clear_toggle),
`ifdef USB_OUT_FIFO_STALL_EN
    .halt(halt),
`endif
    .handshake(handshake), .data_toggle(data_toggle), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .level(level), .pkt_count(pkt_count)
  );

  always #5 clk_48 = ~clk_48;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte must match the head of the scoreboard.
  always @(negedge clk_48) begin
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %0h expected no data", rd_data);
      end else begin
        chk("rd_data", rd_data, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic send(input logic [3:0] ep, input logic din, input logic stp, input int n,
                      input logic [7:0] base, input logic succ, input logic [1:0] exp_hs,
                      input logic exp_commit, input logic clr_end);
    endpoint = ep; direction_in = din; setup = stp; success = 1'b0;
    transaction_active = 1'b1;
    tick();
    chk("hs_during", handshake, exp_hs);
    for (int i = 0; i < n; i++) begin
      data_out = 8'(base + i);
      data_strobe = 1'b1;
      tick();
      data_strobe = 1'b0;
      tick();
    end
    success = succ;
    transaction_active = 1'b0;
    tick();
    if (clr_end) clear_toggle = 1'b1;
    tick();
    clear_toggle = 1'b0;
    if (exp_commit) for (int i = 0; i < n; i++) sb.push_back(8'(base + i));
    chk("hs_after", handshake, 2'b10);
    direction_in = 1'b0; setup = 1'b0; success = 1'b0;
  endtask

  task automatic status(input int lvl, input int pkt, input logic tog);
    chk("level", level, lvl);
    chk("pkt_count", pkt_count, pkt);
    chk("data_toggle", data_toggle, tog);
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int k = 0; k < 300 && rd_valid; k++) tick();
    rd_ready = 1'b0;
    chk("drain_level", level, 0);
    chk("drain_valid", rd_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; usb_rst = 1'b0; transaction_active = 1'b0; direction_in = 1'b0;
    setup = 1'b0; endpoint = 4'd0; data_out = 8'd0; data_strobe = 1'b0;
    success = 1'b0; clear_toggle = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    chk("rst_hs", handshake, 2'b10);
    chk("rst_valid", rd_valid, 0);
    status(0, 0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: good 8-byte packet
    send(4'd1, 0, 0, 8, 8'h01, 1, 2'b00, 1, 0);
    status(8, 1, 1'b1);
    chk("valid_after_commit", rd_valid, 1);
    drain();

    // 2: bad CRC rolls back, then a good 4-byte packet reads back alone
    send(4'd1, 0, 0, 8, 8'h01, 0, 2'b00, 0, 0);
    status(0, 1, 1'b1);
    send(4'd1, 0, 0, 4, 8'h40, 1, 2'b00, 1, 0);
    status(4, 2, 1'b0);
    drain();

    // 3: fill to 65, NAK, pop one, ACK
    send(4'd1, 0, 0, 64, 8'h80, 1, 2'b00, 1, 0);
    status(64, 3, 1'b1);
    send(4'd1, 0, 0, 1, 8'hC0, 1, 2'b00, 1, 0);
    status(65, 4, 1'b0);
    send(4'd1, 0, 0, 4, 8'hD0, 1, 2'b10, 0, 0);
    status(65, 4, 1'b0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("level_pop1", level, 64);
    send(4'd1, 0, 0, 4, 8'hD0, 1, 2'b00, 1, 0);
    status(68, 5, 1'b1);
    drain();

    // 4: three full packets, pointers wrap
    send(4'd1, 0, 0, 64, 8'h00, 1, 2'b00, 1, 0);
    status(64, 6, 1'b0);
    drain();
    send(4'd1, 0, 0, 64, 8'h40, 1, 2'b00, 1, 0);
    status(64, 7, 1'b1);
    drain();
    send(4'd1, 0, 0, 64, 8'h80, 1, 2'b00, 1, 0);
    status(64, 8, 1'b0);
    drain();

    // 5: overflow rollback and ignored transactions
    send(4'd1, 0, 0, 2, 8'h11, 1, 2'b00, 1, 0);
    status(2, 9, 1'b1);
    drain();
    send(4'd1, 0, 0, 65, 8'h20, 1, 2'b00, 0, 0);
    status(0, 9, 1'b1);
    send(4'd2, 0, 0, 4, 8'h60, 1, 2'b10, 0, 0);
    status(0, 9, 1'b1);
    send(4'd1, 1, 0, 4, 8'h61, 1, 2'b10, 0, 0);
    status(0, 9, 1'b1);
    send(4'd1, 0, 1, 4, 8'h62, 1, 2'b10, 0, 0);
    status(0, 9, 1'b1);

    // 6: clear_toggle on the END cycle wins over the flip
    send(4'd1, 0, 0, 3, 8'h30, 1, 2'b00, 1, 1);
    status(3, 10, 1'b0);
    drain();

    // usb_rst mid-RECV drops everything, including committed data
    send(4'd1, 0, 0, 2, 8'hE0, 1, 2'b00, 1, 0);
    status(2, 11, 1'b1);
    endpoint = 4'd1;
    transaction_active = 1'b1;
    tick();
    chk("hs_pre_rst", handshake, 2'b00);
    for (int i = 0; i < 3; i++) begin
      data_out = 8'(8'hA0 + i); data_strobe = 1'b1; tick();
      data_strobe = 1'b0; tick();
    end
    usb_rst = 1'b1;
    tick();
    chk("usbrst_hs", handshake, 2'b10);
    chk("usbrst_valid", rd_valid, 0);
    status(0, 0, 1'b0);
    usb_rst = 1'b0;
    transaction_active = 1'b0;
    sb.delete();
    tick(); tick();
    chk("post_rst_level", level, 0);
    send(4'd1, 0, 0, 2, 8'hF0, 1, 2'b00, 1, 0);
    status(2, 1, 1'b1);
    drain();

    // standalone clear_toggle pulse
    clear_toggle = 1'b1;
    tick();
    clear_toggle = 1'b0;
    chk("clear_pulse", data_toggle, 0);
    send(4'd1, 0, 0, 1, 8'h77, 1, 2'b00, 1, 0);
    status(1, 2, 1'b1);
    drain();

`ifdef USB_OUT_FIFO_STALL_EN
    halt = 1'b1;
    send(4'd1, 0, 0, 4, 8'h55, 1, 2'b11, 0, 0);
    status(0, 2, 1'b1);
    halt = 1'b0;
    tick(); tick();
    chk("halt_fall_toggle", data_toggle, 0);
`endif

    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_bulk_out_fifo.md
Name: usb_bulk_out_fifo

Overview:
Receive buffer for one bulk OUT endpoint, directly downstream of the usb core's transaction interface (endpoint, transaction_active, data_out, data_strobe, success).
- Captures each OUT packet into a circular byte buffer, then commits it on success or rolls it back on failure.
- Drives the handshake and data_toggle back to the core.
- Presents committed bytes to fabric logic (e.g. a UART bridge) through a valid/ready stream.

Parameters:
ENDPOINT, 1, endpoint number this instance responds to (1..15)
DEPTH_LOG2, 7, buffer depth = 2**DEPTH_LOG2 bytes
MAX_PACKET, 64, wMaxPacketSize; ACK only if free space >= MAX_PACKET

Ports:
clk_48  in  1  48 MHz USB clock; the only clock
rst_n  in  1  synchronous active-low reset
usb_rst  in  1  bus reset from the core; same effect as rst_n
endpoint  in  4  endpoint of the current transaction
transaction_active  in  1  high for the duration of a transaction
direction_in  in  1  1 = IN (device to host); this block ignores IN
setup  in  1  SETUP transaction flag; this block ignores SETUP
data_out  in  8  received byte
data_strobe  in  1  byte-valid strobe
success  in  1  packet CRC valid, sampled at transaction end
clear_toggle  in  1  one-cycle pulse; forces expected toggle to DATA0
handshake  out  2  00 ACK, 01 none, 10 NAK, 11 STALL
data_toggle  out  1  expected OUT data toggle
rd_data  out  8  head byte (first-word fall-through)
rd_valid  out  1  committed data available
rd_ready  in  1  consumer accepts rd_data
level  out  DEPTH_LOG2+1  committed byte count
pkt_count  out  8  committed packets, wraps at 256

Behaviour:
Reset values (rst_n low or usb_rst high, synchronous):
- handshake=10 (NAK), data_toggle=0, rd_valid=0, level=0, pkt_count=0.
- All pointers cleared; state = IDLE.
- Reset mid-packet drops the partial packet.

Selection and edge detection:
- sel = transaction_active && endpoint==ENDPOINT && !direction_in && !setup.
- Rising edge of sel (registered previous value) starts a transaction.
- Byte capture uses the rising edge of data_strobe (registered compare), so one byte is taken per strobe pulse regardless of pulse width.

State machine:
- IDLE: handshake=NAK.
  - On sel rise with free = 2**DEPTH_LOG2 - level >= MAX_PACKET: shadow_ptr <= wr_ptr, byte_cnt <= 0, ovf <= 0, handshake <= ACK, go to RECV.
  - On sel rise without enough free space: handshake <= NAK, go to DROP.
- RECV:
  - Each strobe edge: if byte_cnt < MAX_PACKET, mem[shadow_ptr] <= data_out, shadow_ptr++, byte_cnt++; otherwise ovf <= 1 and the byte is not written.
  - On transaction_active fall, go to END.
- DROP: no writes. On transaction_active fall, go to IDLE.
- END (one cycle):
  - If success && !ovf: wr_ptr <= shadow_ptr, data_toggle flips, pkt_count++.
  - Otherwise wr_ptr is unchanged (rollback) and the toggle is unchanged.
  - Go to IDLE; handshake returns to NAK.
- A zero-length packet with success commits 0 bytes, flips the toggle and increments pkt_count.

Read side:
- rd_valid = (level != 0); rd_data = mem[rd_ptr].
- Pop on rd_valid && rd_ready: rd_ptr++.
- Pointers are DEPTH_LOG2+1 bits wide; level = wr_ptr - rd_ptr, modulo arithmetic; wrap-around is seamless.
- Commit and pop in the same cycle: level = old level + committed bytes - 1.
- Shadow bytes are never visible to the reader before commit.

Toggle:
- clear_toggle or usb_rst forces data_toggle=0.
- If clear_toggle coincides with END, clear wins.

Optional Feature:
Macro: USB_OUT_FIFO_STALL_EN
- With the macro defined: adds input port halt (1 bit).
  - While halt=1, every selected OUT transaction gets handshake=11 (STALL), goes to DROP and writes nothing.
  - Takes priority over the ACK/NAK decision.
  - The toggle is untouched while halted and is cleared to 0 on halt falling.
- Without the macro: no halt port and STALL is never driven.

Test Plan:
1. OUT EP1, 8 bytes 0x01..0x08, success=1 -> handshake ACK during the transaction; after END level=8, pkt_count=1, data_toggle=1; rd_ready=1 streams 0x01..0x08, then rd_valid=0.
2. Same 8 bytes with success=0 -> level stays 0, data_toggle stays 0, pkt_count=0; the next good 4-byte packet reads back only its own 4 bytes.
3. Fill to level=65 with rd_ready=0, then send an OUT -> handshake NAK, nothing written; pop 1 byte (level=64), resend -> ACK and commit.
4. Sequence of 3x64-byte packets, each drained, with DEPTH_LOG2=7 -> pointer wrap occurs; all 192 bytes read in order; pkt_count=3.
5. 65-byte OUT -> ovf set, rollback, level unchanged; transactions on EP2, IN, and SETUP on EP1 -> no writes, no toggle change.
6. clear_toggle pulsed on the END cycle -> data_toggle=0; usb_rst mid-RECV -> level=0, handshake=NAK next cycle. With USB_OUT_FIFO_STALL_EN and halt=1 -> handshake=11, no writes.
